// File: rtl/dp_ram_bytewise_pkg.sv
// Shared types and helpers for the byte-strobed dual-port scratchpad RAM.
package dp_ram_pkg;

   localparam int unsigned RDW_OLD = 0;
   localparam int unsigned RDW_NEW = 1;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int unsigned MAX_W  = 256;
   localparam int unsigned MAX_BE = MAX_W / 8;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Replace the strobed byte lanes of old_w with those of new_w.
   function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_w,
                                                 input logic [MAX_W-1:0]  new_w,
                                                 input logic [MAX_BE-1:0] be);
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MAX_BE); i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dp_ram_bytewise_if.sv
// One RAM port: valid/ready request channel plus read-return and error pulses.
interface dp_ram_bytewise_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 6
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              valid;
   logic              ready;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              err;

   modport master (
      output valid, wr, addr, wdata, be,
      input  ready, rdata, rvalid, err
   );

   modport slave (
      input  valid, wr, addr, wdata, be,
      output ready, rdata, rvalid, err
   );

endinterface

// File: rtl/dp_ram_bytewise_rd_pipe.sv
// Read-return delay line: RD_LAT stages of valid/data; data holds between valid pulses.
module dp_ram_rd_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic [RD_LAT-1:0] r_valid;
   logic [DATA_W-1:0] r_data [RD_LAT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         for (int k = 0; k < int'(RD_LAT); k++) r_data[k] <= '0;
      end else begin
         r_valid[0] <= i_valid;
         if (i_valid) r_data[0] <= i_data;
         for (int k = 1; k < int'(RD_LAT); k++) begin
            r_valid[k] <= r_valid[k-1];
            if (r_valid[k-1]) r_data[k] <= r_data[k-1];
         end
      end
   end

   assign o_valid = r_valid[RD_LAT-1];
   assign o_data  = r_data[RD_LAT-1];

endmodule

// File: rtl/dp_ram_bytewise.sv
// True dual-port byte-strobed RAM with post-reset clear engine, collision merge and
// selectable cross-port read-during-write behaviour.
module dp_ram_bytewise
   import dp_ram_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned RDW_MODE = 0
) (
   input  logic             clk,
   input  logic             rst,
   dp_ram_bytewise_if.slave port_a,
   dp_ram_bytewise_if.slave port_b,
   output logic             init_done,
   output logic             collision
);

   localparam bit BYPASS = (RDW_MODE == RDW_NEW);

   logic [DATA_W-1:0] r_mem [DEPTH];

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_ready;
   logic              r_init_done;
   logic              r_collision;
   logic              r_a_err;
   logic              r_b_err;

   logic              w_a_acc, w_b_acc;
   logic              w_a_in, w_b_in;
   logic              w_a_wr, w_b_wr;
   logic              w_a_rd, w_b_rd;
   logic              w_same;
   logic              w_coll_wr;
   logic [ADDR_W-1:0] w_a_idx, w_b_idx;
   logic [DATA_W-1:0] w_a_old, w_b_old;
   logic [DATA_W-1:0] w_a_word, w_b_word;
   logic [DATA_W-1:0] w_a_rdata, w_b_rdata;

   // Clear engine: one word per cycle, then open both ports.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= CLEAR;
         r_cnt       <= '0;
         r_ready     <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + ADDR_W'(1);
               if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                  r_state     <= RUN;
                  r_ready     <= 1'b1;
                  r_init_done <= 1'b1;
               end
            end
            RUN: begin
               r_ready     <= 1'b1;
               r_init_done <= 1'b1;
            end
         endcase
      end
   end

   assign w_a_acc = port_a.valid && r_ready;
   assign w_b_acc = port_b.valid && r_ready;
   assign w_a_in  = 32'(port_a.addr) < DEPTH;
   assign w_b_in  = 32'(port_b.addr) < DEPTH;
   assign w_a_idx = w_a_in ? port_a.addr : '0;
   assign w_b_idx = w_b_in ? port_b.addr : '0;
   assign w_a_wr  = w_a_acc && port_a.wr && w_a_in;
   assign w_b_wr  = w_b_acc && port_b.wr && w_b_in;
   assign w_a_rd  = w_a_acc && !port_a.wr;
   assign w_b_rd  = w_b_acc && !port_b.wr;
   assign w_same  = (port_a.addr == port_b.addr);
   assign w_coll_wr = w_a_wr && w_b_wr && w_same;

   assign w_a_old = r_mem[w_a_idx];
   assign w_b_old = r_mem[w_b_idx];

   // On a same-address double write, A's lanes are layered over B's merged word.
   assign w_b_word = DATA_W'(be_merge(MAX_W'(w_b_old), MAX_W'(port_b.wdata), MAX_BE'(port_b.be)));
   assign w_a_word = DATA_W'(be_merge(MAX_W'(w_coll_wr ? w_b_word : w_a_old),
                                      MAX_W'(port_a.wdata), MAX_BE'(port_a.be)));

   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_mem[r_cnt] <= '0;
      end else begin
         if (w_b_wr && !w_coll_wr) r_mem[w_b_idx] <= w_b_word;
         if (w_a_wr)               r_mem[w_a_idx] <= w_a_word;
      end
   end

   // Out-of-range reads return zero; bypass picks up the other port's post-write word.
   assign w_a_rdata = !w_a_in                         ? '0       :
                      (BYPASS && w_b_wr && w_same)    ? w_b_word : w_a_old;
   assign w_b_rdata = !w_b_in                         ? '0       :
                      (BYPASS && w_a_wr && w_same)    ? w_a_word : w_b_old;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_collision <= 1'b0;
         r_a_err     <= 1'b0;
         r_b_err     <= 1'b0;
      end else begin
         r_collision <= w_a_acc && port_a.wr && w_b_acc && port_b.wr && w_same;
         r_a_err     <= w_a_acc && !w_a_in;
         r_b_err     <= w_b_acc && !w_b_in;
      end
   end

   dp_ram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_a (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_a_rd),
      .i_data  (w_a_rdata),
      .o_valid (port_a.rvalid),
      .o_data  (port_a.rdata)
   );

   dp_ram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_rd_pipe_b (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_b_rd),
      .i_data  (w_b_rdata),
      .o_valid (port_b.rvalid),
      .o_data  (port_b.rdata)
   );

   assign port_a.ready = r_ready;
   assign port_b.ready = r_ready;
   assign port_a.err   = r_a_err;
   assign port_b.err   = r_b_err;
   assign init_done    = r_init_done;
   assign collision    = r_collision;

endmodule

// File: tb/tb_dp_ram_bytewise.sv
// Scoreboard bench: two RAM configurations share one stimulus stream and a byte-level memory model.
module tb_dp_ram_bytewise;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;
   localparam int unsigned D0 = 64, L0 = 1, M0 = 0;
   localparam int unsigned D1 = 48, L1 = 2, M1 = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic          s_av, s_aw, s_bv, s_bw;
   logic [AW-1:0] s_aa, s_ba;
   logic [DW-1:0] s_ad, s_bd;
   logic [3:0]    s_abe, s_bbe;

   dp_ram_bytewise_if #(.DATA_W(DW), .ADDR_W(AW)) ia0 ();
   dp_ram_bytewise_if #(.DATA_W(DW), .ADDR_W(AW)) ib0 ();
   dp_ram_bytewise_if #(.DATA_W(DW), .ADDR_W(AW)) ia1 ();
   dp_ram_bytewise_if #(.DATA_W(DW), .ADDR_W(AW)) ib1 ();

   assign ia0.valid = s_av;  assign ia1.valid = s_av;
   assign ia0.wr    = s_aw;  assign ia1.wr    = s_aw;
   assign ia0.addr  = s_aa;  assign ia1.addr  = s_aa;
   assign ia0.wdata = s_ad;  assign ia1.wdata = s_ad;
   assign ia0.be    = s_abe; assign ia1.be    = s_abe;
   assign ib0.valid = s_bv;  assign ib1.valid = s_bv;
   assign ib0.wr    = s_bw;  assign ib1.wr    = s_bw;
   assign ib0.addr  = s_ba;  assign ib1.addr  = s_ba;
   assign ib0.wdata = s_bd;  assign ib1.wdata = s_bd;
   assign ib0.be    = s_bbe; assign ib1.be    = s_bbe;

   logic init0, col0, init1, col1;

   dp_ram_bytewise #(.DATA_W(DW), .DEPTH(D0), .ADDR_W(AW), .RD_LAT(L0), .RDW_MODE(M0)) u_dut0 (
      .clk(clk), .rst(rst), .port_a(ia0), .port_b(ib0), .init_done(init0), .collision(col0));

   dp_ram_bytewise #(.DATA_W(DW), .DEPTH(D1), .ADDR_W(AW), .RD_LAT(L1), .RDW_MODE(M1)) u_dut1 (
      .clk(clk), .rst(rst), .port_a(ia1), .port_b(ib1), .init_done(init1), .collision(col1));

   // kind: 0 = read return, 1 = error pulse, 2 = collision pulse
   typedef struct {
      int            kind;
      int            c;
      int            p;
      int            cyc;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           q_exp[$];
   logic [DW-1:0] mem [2][64];

   function automatic int dep(input int c);  return (c == 0) ? D0 : D1; endfunction
   function automatic int lat(input int c);  return (c == 0) ? L0 : L1; endfunction
   function automatic int mode(input int c); return (c == 0) ? M0 : M1; endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] base, input logic [DW-1:0] wd,
                                           input logic [3:0] be);
      logic [7:0] bytes [4];
      for (int i = 0; i < 4; i++) bytes[i] = be[i] ? wd[8*i +: 8] : base[8*i +: 8];
      return {bytes[3], bytes[2], bytes[1], bytes[0]};
   endfunction

   task automatic push(input int kind, input int c, input int p, input int cy, input logic [DW-1:0] d);
      ev_t e;
      e.kind = kind; e.c = c; e.p = p; e.cyc = cy; e.data = d;
      q_exp.push_back(e);
   endtask

   // Reference behaviour for the request pair driven in cycle k.
   task automatic model(input int k);
      logic [DW-1:0] nm [64];
      logic          ai, bi;
      for (int c = 0; c < 2; c++) begin
         ai = int'(s_aa) < dep(c);
         bi = int'(s_ba) < dep(c);
         for (int i = 0; i < 64; i++) nm[i] = mem[c][i];
         if (s_bv && s_bw && bi) nm[s_ba] = merge(nm[s_ba], s_bd, s_bbe);
         if (s_av && s_aw && ai) nm[s_aa] = merge(nm[s_aa], s_ad, s_abe);
         if (s_av && !s_aw)
            push(0, c, 0, k + lat(c), !ai ? '0 : (mode(c) == 1 ? nm[s_aa] : mem[c][s_aa]));
         if (s_bv && !s_bw)
            push(0, c, 1, k + lat(c), !bi ? '0 : (mode(c) == 1 ? nm[s_ba] : mem[c][s_ba]));
         if (s_av && !ai) push(1, c, 0, k + 1, '0);
         if (s_bv && !bi) push(1, c, 1, k + 1, '0);
         if (s_av && s_aw && s_bv && s_bw && s_aa == s_ba) push(2, c, 0, k + 1, '0);
         for (int i = 0; i < 64; i++) mem[c][i] = nm[i];
      end
   endtask

   task automatic match(input int kind, input int c, input int p, input logic [DW-1:0] d);
      int idx;
      idx = -1;
      for (int i = 0; i < q_exp.size(); i++) begin
         if (idx < 0 && q_exp[i].kind == kind && q_exp[i].c == c && q_exp[i].p == p) idx = i;
      end
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL unexpected_pulse kind%0d dut%0d port%0d @cyc %0d: got pulse expected none",
                  kind, c, p, cyc);
      end else begin
         if (q_exp[idx].cyc != cyc || (kind == 0 && q_exp[idx].data !== d)) begin
            errors++;
            $display("FAIL pulse kind%0d dut%0d port%0d: got cyc %0d data %08h expected cyc %0d data %08h",
                     kind, c, p, cyc, d, q_exp[idx].cyc, q_exp[idx].data);
         end
         q_exp.delete(idx);
      end
   endtask

   task automatic get_obs(input int c, input int p, output logic rv, output logic [DW-1:0] rd,
                          output logic er);
      if (c == 0 && p == 0)      begin rv = ia0.rvalid; rd = ia0.rdata; er = ia0.err; end
      else if (c == 0)           begin rv = ib0.rvalid; rd = ib0.rdata; er = ib0.err; end
      else if (p == 0)           begin rv = ia1.rvalid; rd = ia1.rdata; er = ia1.err; end
      else                       begin rv = ib1.rvalid; rd = ib1.rdata; er = ib1.err; end
   endtask

   // Monitor: every observed pulse must consume a matching expectation.
   always @(negedge clk) begin
      logic          rv, er;
      logic [DW-1:0] rd;
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 2; p++) begin
            get_obs(c, p, rv, rd, er);
            if (rv === 1'b1) match(0, c, p, rd);
            if (er === 1'b1) match(1, c, p, '0);
         end
      end
      if (col0 === 1'b1) match(2, 0, 0, '0);
      if (col1 === 1'b1) match(2, 1, 0, '0);
   end

   task automatic op(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic [3:0] abe, input logic bv, input logic bw, input logic [AW-1:0] ba,
                     input logic [DW-1:0] bd, input logic [3:0] bbe);
      @(negedge clk);
      s_av = av; s_aw = aw; s_aa = aa; s_ad = ad; s_abe = abe;
      s_bv = bv; s_bw = bw; s_ba = ba; s_bd = bd; s_bbe = bbe;
      if (av || bv) check("ready", {ia0.ready, ib0.ready, ia1.ready, ib1.ready}, 64'hF);
      model(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Ready/init_done must stay low for exactly DEPTH cycles after release.
   task automatic release_and_check_init();
      logic e0, e1;
      @(negedge clk);
      rst = 1'b1;
      for (int j = 0; j < 67; j++) begin
         e0 = (j >= int'(D0));
         e1 = (j >= int'(D1));
         check("init", {ia0.ready, ib0.ready, init0, ia1.ready, ib1.ready, init1},
               {58'd0, e0, e0, e0, e1, e1, e1});
         @(negedge clk);
      end
   endtask

   initial begin
      logic          av, bv;
      logic [AW-1:0] ra, rb;
      rst = 1'b0;
      s_av = 0; s_aw = 0; s_aa = '0; s_ad = '0; s_abe = '0;
      s_bv = 0; s_bw = 0; s_ba = '0; s_bd = '0; s_bbe = '0;
      for (int c = 0; c < 2; c++) for (int i = 0; i < 64; i++) mem[c][i] = '0;

      repeat (3) @(negedge clk);
      check("rst_outs", {ia0.ready, ia0.rvalid, ia0.err, init0, col0, ia1.ready, ib1.rvalid, init1},
            64'd0);
      check("rst_rdata", {ia0.rdata, ib1.rdata}, 64'd0);
      release_and_check_init();

      // Every word reads back zero after the clear.
      for (int i = 0; i < 64; i++)
         op(1'b1, 1'b0, AW'(i), '0, '0, 1'b1, 1'b0, AW'(63 - i), '0, '0);
      idle(3);

      // Partial strobe write then read-back.
      op(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 4'b0101, 1'b0, 1'b0, '0, '0, '0);
      op(1'b1, 1'b0, 6'd5, '0, '0, 1'b0, 1'b0, '0, '0, '0);
      // Same-address double write, A wins overlapping lanes.
      op(1'b1, 1'b1, 6'd9, 32'h11111111, 4'b0011, 1'b1, 1'b1, 6'd9, 32'h22222222, 4'b1111);
      op(1'b1, 1'b0, 6'd9, '0, '0, 1'b1, 1'b0, 6'd9, '0, '0);
      // Cross-port read during write.
      op(1'b1, 1'b1, 6'd3, 32'h12345678, 4'b1111, 1'b0, 1'b0, '0, '0, '0);
      op(1'b1, 1'b1, 6'd3, 32'hCAFE0000, 4'b1111, 1'b1, 1'b0, 6'd3, '0, '0);
      op(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 6'd3, '0, '0);
      // Zero-strobe write is a no-op; then back-to-back reads on B.
      op(1'b1, 1'b1, 6'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 8; i++)
         op(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, AW'(i), '0, '0);
      // Out-of-range read and write (only beyond DEPTH for the 48-word instance).
      op(1'b1, 1'b1, 6'd50, 32'hA5A5A5A5, 4'b1111, 1'b1, 1'b0, 6'd63, '0, '0);
      op(1'b1, 1'b0, 6'd50, '0, '0, 1'b1, 1'b0, 6'd5, '0, '0);
      idle(4);

      // Randomised traffic, biased towards a few addresses to provoke conflicts.
      for (int n = 0; n < 400; n++) begin
         av = ($urandom_range(0, 3) != 0);
         bv = ($urandom_range(0, 3) != 0);
         ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
         rb = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
         op(av, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
            bv, 1'($urandom_range(0, 1)), rb, $urandom, 4'($urandom_range(0, 15)));
      end
      idle(5);
      check("drain", 64'(q_exp.size()), 64'd0);

      // Reset with reads in flight: the 2-cycle instance's returns must be lost.
      op(1'b1, 1'b1, 6'd2, 32'h0BADF00D, 4'b1111, 1'b0, 1'b0, '0, '0, '0);
      op(1'b1, 1'b0, 6'd2, '0, '0, 1'b1, 1'b0, 6'd10, '0, '0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      s_av = 1'b0; s_bv = 1'b0;
      q_exp.delete();
      for (int c = 0; c < 2; c++) for (int i = 0; i < 64; i++) mem[c][i] = '0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("rst_mid_valid", {ia0.rvalid, ib0.rvalid, ia1.rvalid, ib1.rvalid,
                                 ia0.ready, ia1.ready, init0, init1}, 64'd0);
         check("rst_mid_rdata", {ia0.rdata, ia1.rdata}, 64'd0);
      end
      release_and_check_init();
      op(1'b1, 1'b0, 6'd2, '0, '0, 1'b1, 1'b0, 6'd10, '0, '0);
      idle(5);
      check("drain_final", 64'(q_exp.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
